// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register write arbiter.
//   state_t   : arbiter FSM encoding (2'd3 is unused and recovers to IDLE)
//   DEF_*     : default requester count and data width
//   rr_pick() : rotating-priority winner search starting at a pointer
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  // Upper bound on requesters the search function handles; req is
  // zero-extended to this width by the caller.
  localparam int MAX_REQ = 32;

  // Returns the first asserted request at or after ptr, wrapping modulo n.
  // Scanning from the far end downward lets the closest hit overwrite the
  // rest, so the result is the lowest rotated distance from ptr.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int ptr,
                                 input int n);
    int idx;
    int win;
    win = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sync_reg_bank.sv
// WIDTH-bit storage register with synchronous clear and load enable.
//   clk    : rising-edge clock
//   rst    : synchronous active-high clear to zero
//   i_load : capture i_d on the next rising edge
//   i_d    : data to capture
//   o_q    : stored value
module sync_reg_bank
  import shared_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared register.
// A winner is chosen in IDLE, granted for one cycle (GRANT), written into
// the register if it still requests, then acknowledged for one cycle (ACK).
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : per-requester level write request
//   wdata   : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant (valid during GRANT)
//   ack     : one-cycle one-hot write-complete pulse (during ACK)
//   q       : shared register contents
//   busy    : high whenever the FSM is outside IDLE
//   last_id : index of the most recent requester that completed a write
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [ID_W-1:0]          last_id
);

  state_t             r_state;
  logic [ID_W-1:0]    r_win;
  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic [ID_W-1:0]    r_last_id;

  logic [ID_W-1:0]    w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_load;
  logic [WIDTH-1:0]   w_wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  assign w_pick    = ID_W'(rr_pick(MAX_REQ'(req), int'(r_ptr), NUM_REQ));
  assign w_pick_oh = NUM_REQ'(1) << w_pick;
  assign w_win_oh  = NUM_REQ'(1) << r_win;

  // The write commits only if the winner still requests at the end of GRANT.
  assign w_load = (r_state == GRANT) && req[r_win];

  sync_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_d    (w_wdata_arr[r_win]),
    .o_q    (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_win     <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_last_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (|req) begin
            r_win   <= w_pick;
            r_gnt   <= w_pick_oh;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          r_gnt <= '0;
          if (req[r_win]) begin
            // last_id and ptr move here so they are already visible while
            // ack is high.
            r_ack     <= w_win_oh;
            r_last_id <= r_win;
            r_ptr     <= (r_win == ID_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
            r_state   <= ACK;
          end else begin
            // Winner withdrew: abort with no write and pointer untouched.
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign busy    = r_busy;
  assign last_id = r_last_id;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=8).
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  last_id;

  int n_checks;
  int n_fail;

  shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .busy    (busy),
    .last_id (last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int idx, input logic [7:0] v);
    wdata[idx*8 +: 8] = v;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    req   = 4'b1111;
    wdata = '0;

    // 1. Reset with all requests high
    step();
    step();
    check("rst_q",       32'(q),       32'h0);
    check("rst_gnt",     32'(gnt),     32'h0);
    check("rst_ack",     32'(ack),     32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_last_id", 32'(last_id), 32'h0);
    rst = 1'b0;
    step();
    check("rst_first_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();                                   // abort back to IDLE
    check("rst_abort_busy", 32'(busy), 32'h0);

    // 2. Single write from requester 2
    req = 4'b0100;
    set_wd(2, 8'hA5);
    step();
    check("single_gnt",  32'(gnt),  32'b0100);
    check("single_busy", 32'(busy), 32'h1);
    check("single_q_hold", 32'(q),  32'h0);
    step();
    check("single_q",       32'(q),       32'hA5);
    check("single_ack",     32'(ack),     32'b0100);
    check("single_last_id", 32'(last_id), 32'h2);
    check("single_gnt_off", 32'(gnt),     32'h0);
    req = 4'b0000;
    step();
    check("single_busy_off", 32'(busy), 32'h0);
    check("single_ack_off",  32'(ack),  32'h0);

    // 3. Round-robin from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    wdata = 32'h13121110;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(1) << i);
      step();
      check($sformatf("rr_ack%0d", i), 32'(ack), 32'(1) << i);
      check($sformatf("rr_q%0d", i),   32'(q),   32'h10 + 32'(i));
      req[i] = 1'b0;
      step();
    end
    check("rr_final_q",   32'(q),       32'h13);
    check("rr_final_lid", 32'(last_id), 32'h3);
    req = 4'b0010;
    step();
    check("rr_gnt1_again", 32'(gnt), 32'b0010);
    step();
    check("rr_ack1_again", 32'(ack), 32'b0010);
    req = 4'b0000;
    step();
    req = 4'b0011;                            // ptr=2: search 2,3,0 -> 0
    step();
    check("rr_wrap_gnt0", 32'(gnt), 32'b0001);
    step();
    check("rr_wrap_ack0", 32'(ack), 32'b0001);
    check("rr_wrap_q",    32'(q),   32'h10);
    req = 4'b0000;
    step();

    // 4. Abort: requester 1 withdraws during GRANT
    req = 4'b0010;
    set_wd(1, 8'h3C);
    step();
    check("abort_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    check("abort_ack",     32'(ack),     32'h0);
    check("abort_busy",    32'(busy),    32'h0);
    check("abort_q",       32'(q),       32'h10);
    check("abort_last_id", 32'(last_id), 32'h0);
    step();
    check("abort_ack_late", 32'(ack), 32'h0);
    req = 4'b0010;
    step();
    check("abort_regnt", 32'(gnt), 32'b0010);
    step();
    check("abort_rewrite_q", 32'(q), 32'h3C);
    req = 4'b0000;
    step();

    // 5. Reset during ACK
    req = 4'b0001;
    set_wd(0, 8'hFF);
    step();
    step();
    check("midrst_q_pre", 32'(q), 32'hFF);
    rst = 1'b1;
    req = 4'b0000;
    step();
    check("midrst_q",    32'(q),       32'h0);
    check("midrst_ack",  32'(ack),     32'h0);
    check("midrst_busy", 32'(busy),    32'h0);
    check("midrst_lid",  32'(last_id), 32'h0);
    rst = 1'b0;
    req = 4'b1111;
    step();
    check("midrst_ptr0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();

    // 6. Late arrival of req[3] during ACK of requester 0
    req = 4'b0001;
    set_wd(0, 8'h55);
    set_wd(3, 8'h77);
    step();
    step();
    check("late_ack0", 32'(ack), 32'b0001);
    req = 4'b1000;
    step();
    check("late_idle_gnt", 32'(gnt), 32'h0);
    check("late_idle_q",   32'(q),   32'h55);
    step();
    check("late_gnt3", 32'(gnt), 32'b1000);
    check("late_q_hold", 32'(q), 32'h55);
    step();
    check("late_q3",   32'(q),   32'h77);
    check("late_ack3", 32'(ack), 32'b1000);
    req = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter and sequencer for one shared WIDTH-bit register built from synchronous-reset D flip-flops.
- NUM_REQ requesters compete to write the register. The block grants one requester at a time, loads that requester's data, pulses ack, and exposes the register contents to all requesters.
- Sits between requester logic and the flip-flop storage. It is the only writer of the register.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 8, register data width (>=1).
- ID_W, $clog2(NUM_REQ), width of requester index (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester write request, level; held high until own ack seen
- wdata  input  NUM_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when no grant
- ack  output  NUM_REQ  one-cycle one-hot write-complete pulse
- q  output  WIDTH  shared register value
- busy  output  1  high whenever the FSM is not in IDLE
- last_id  output  ID_W  index of the most recent requester that completed a write

Behaviour:
- Reset: one clock and one reset only. rst is sampled on the rising clk edge, synchronous, active-high, and has priority over everything else. After a reset edge:
  - q=0, gnt=0, ack=0, busy=0, last_id=0
  - state=IDLE, round-robin pointer ptr=0
- FSM states:
  - IDLE: if any req is high, select a winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt = one-hot of the winner. If req[winner] is still high at the end of the cycle, capture wdata[winner] into q and go to ACK. If req[winner] is low, abort: go to IDLE with no write, no ack, and ptr unchanged.
  - ACK: ack = one-hot of the winner for exactly this cycle; gnt=0. Set last_id=winner and ptr=(winner+1) mod NUM_REQ. Then go to IDLE. All req values are ignored in this cycle.
- Winner selection: search for the first asserted req starting at index ptr and wrapping upward, ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1. The winner is registered at the IDLE->GRANT transition and stays stable through GRANT and ACK.
- Latency and timing:
  - Cycle 0: IDLE samples req.
  - Cycle 1: GRANT; gnt is valid.
  - Cycle 2: ACK; q holds the new data and ack is high.
  - Cycle 3: IDLE.
  - Minimum spacing between two writes is 3 cycles.
- Requester protocol:
  - A requester drops req in the cycle after it sees ack.
  - If req is still high in the IDLE that follows ack, that is a new request.
- q changes only on the GRANT->ACK edge or on reset. It is stable at all other times.
- Simultaneous events:
  - rst together with any req: reset wins.
  - req arriving during GRANT or ACK: held off until the next IDLE.
  - A new higher-priority req arriving during GRANT does not pre-empt the current winner.
- Reset mid-operation: a reset in GRANT or ACK aborts the transaction. No ack is produced and q=0 on the next cycle.
- wdata is don't-care except wdata[winner] during GRANT.

Decomposition:
- Package shared_reg_pkg contains:
  - state typedef: IDLE=2'd0, GRANT=2'd1, ACK=2'd2; 2'd3 is illegal and returns to IDLE.
  - default NUM_REQ and WIDTH constants.
  - a rotate-priority function that returns the winner index given req and ptr.
- One sub-module, sync_reg_bank: a WIDTH-wide register with clk, rst (synchronous active-high clear to 0), load enable and d/q. The arbiter drives load = (state==GRANT && req[winner]) and d = wdata[winner].

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0, last_id=0. The first grant after release goes to requester 0.
2. Single write: req=4'b0100, wdata[2]=8'hA5 -> cycle 1 gnt=4'b0100 and busy=1; cycle 2 q=8'hA5, ack=4'b0100, last_id=2; cycle 3 busy=0.
3. Round-robin: req=4'b1111 held, each requester drops req after its own ack; data 8'h10/8'h11/8'h12/8'h13 -> grant order 0,1,2,3, final q=8'h13, ptr=0. Then grant to 1, then req=4'b0011 -> next grant goes to 0, not 1.
4. Abort: req=4'b0010 with wdata[1]=8'h3C; drop req[1] during GRANT -> no ack, q keeps its previous value, last_id unchanged. Re-raising req[1] yields gnt=4'b0010 again.
5. Reset mid-operation: assert rst during ACK of a write with wdata=8'hFF -> next cycle q=0, ack=0, state IDLE, ptr=0.
6. Late arrival: req[3] rises during ACK of requester 0's write -> ignored in that cycle; IDLE next cycle grants 3, with q updated two cycles later.
